param_cipher_pipe: RTL and testbench
====================================

PARAM_CIPHER_PIPE -- requirements
Module: param_cipher_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range is 2 or more.
REQ-002 Parameter SHIFT, default 1, rotate amount; legal range is 0..WIDTH-1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_data  input  WIDTH  plaintext (encrypt) or ciphertext (decrypt).
REQ-008 in_mode  input  1  0 = encrypt, 1 = decrypt; sampled per beat with in_data.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 out_data  output  WIDTH  transformed data.
REQ-012 out_mode  output  1  mode the out_data beat was processed with.
REQ-013 out_count  output  16  count of completed output beats; wraps 0xFFFF to 0x0000.

Function
REQ-014 Transfer occurs on a cycle when valid and ready are both high; no other cycle moves data.
REQ-015 Three register stages S1, S2, S3, each holding data, mode and a valid bit; S3 drives out_data, out_mode and out_valid directly.
REQ-016 Encrypt, per beat:
- S1 = rotate-right(in_data, SHIFT).
- S2 = S1 XOR (S1 shifted left 1, truncated to WIDTH); so bit0 = S1[0] and bit i = S1[i] XOR S1[i-1].
- S3 = bitwise NOT of S2.
REQ-017 Decrypt, per beat:
- S1 = bitwise NOT of in_data.
- S2 = prefix XOR from LSB: b[0] = S1[0], b[i] = S1[i] XOR b[i-1].
- S3 = rotate-left(S2, SHIFT).
REQ-018 For every WIDTH, SHIFT and x, decrypt(encrypt(x)) SHALL equal x.
REQ-019 Mode travels with its beat; mixed modes in consecutive beats are processed independently with no bubble.
REQ-020 Latency is 3 cycles from in_data accept to out_valid when out_ready is held high; throughput is 1 beat per cycle.
REQ-021 Stage k advances when its successor is empty or the successor is itself advancing this cycle.
REQ-022 in_ready = NOT S1.valid OR S1 advancing; it is combinational from out_ready through the stage chain (no skid buffer).
REQ-023 While out_valid=1 and out_ready=0, out_data and out_mode SHALL hold stable.
REQ-024 Under stall, up to 3 beats are held without loss or duplication.
REQ-025 out_count increments by 1 on each output transfer.

Reset
REQ-026 Reset is asynchronous and active-low. While rst_n is low:
- all valid bits, data registers and mode registers are 0;
- out_valid=0, out_data=0, out_mode=0, out_count=0;
- in_ready=1.
REQ-027 Reset asserted mid-operation discards all in-flight beats; no partial beat appears after release.

Structure
REQ-028 A shared package cipher_pkg holds:
- mode constants MODE_ENC=0 and MODE_DEC=1;
- transform functions rotr, rotl, gray_fwd and gray_inv, parameterised by width.
REQ-029 One sub-module, cipher_pipe_stage: a parameterised valid/ready register slice holding data and mode, instantiated three times.

Verification
REQ-030 WIDTH=8, SHIFT=1, encrypt:
- 0x01 -> 0x7F, 3 cycles after accept;
- 0xA5 -> 0x89.
REQ-031 WIDTH=8, SHIFT=1, decrypt 0x7F -> 0x01 and 0x89 -> 0xA5, each with out_mode=1.
REQ-032 Back-to-back 256 beats alternating modes, out_ready=1 -> one output per cycle, all correct, out_count=256 (0x0100).
REQ-033 Fill 3 beats, then out_ready=0 for 5 cycles:
- in_ready=0 once full and out_data stable throughout;
- after release, the 3 beats appear in order with no loss or duplication.
REQ-034 Assert rst_n low with 2 beats in flight:
- out_valid=0 and out_count=0 at once;
- after release, the first new beat appears exactly 3 cycles after accept.
REQ-035 Random round-trip with WIDTH=13, SHIFT=5: encrypt output fed to decrypt input -> every beat recovers the original data.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared mode encoding and width-generic bit transforms for the cipher pipe.
package cipher_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Widest data path the transforms support; callers pass their real width.
  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // Ones in the low w bits.
  function automatic word_t width_mask(input int unsigned w);
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Rotate the low w bits right by s (s < w).
  function automatic word_t rotr(input word_t x, input int unsigned w, input int unsigned s);
    word_t xm;
    xm = x & width_mask(w);
    return ((xm >> s) | (xm << (w - s))) & width_mask(w);
  endfunction

  // Rotate the low w bits left by s (s < w).
  function automatic word_t rotl(input word_t x, input int unsigned w, input int unsigned s);
    word_t xm;
    xm = x & width_mask(w);
    return ((xm << s) | (xm >> (w - s))) & width_mask(w);
  endfunction

  // Bit i becomes x[i] ^ x[i-1]; bit 0 passes through.
  function automatic word_t gray_fwd(input word_t x, input int unsigned w);
    word_t xm;
    xm = x & width_mask(w);
    return (xm ^ (xm << 1)) & width_mask(w);
  endfunction

  // Prefix XOR from the LSB upward, the inverse of gray_fwd.
  function automatic word_t gray_inv(input word_t x, input int unsigned w);
    word_t r;
    r = x & width_mask(w);
    for (int unsigned k = 1; k < MAX_W; k = k << 1) begin
      r = r ^ (r << k);
    end
    return r & width_mask(w);
  endfunction

endpackage

// File: rtl/cipher_pipe_stage.sv
// One valid/ready register slice carrying a data word and its mode bit.
module cipher_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         up_mode,
  output logic         up_ready_c,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  output logic         dn_mode,
  input  logic         dn_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         mode_q, mode_d;

  // Slot is free when empty or when its current beat leaves this cycle.
  assign up_ready_c = !valid_q || dn_ready;

  // Load a new beat (or a bubble) whenever the slot frees up.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    if (up_ready_c) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
        mode_d = up_mode;
      end
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_mode  = mode_q;

endmodule

// File: rtl/param_cipher_pipe.sv
// Three-stage rotate/gray/invert cipher with per-beat encrypt/decrypt mode.
module param_cipher_pipe
  import cipher_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [15:0]      out_count
);

  logic             s1_valid, s1_mode, s2_valid, s2_mode;
  logic [WIDTH-1:0] s1_data, s2_data;
  logic             s2_ready_c, s3_ready_c;
  logic [WIDTH-1:0] s1_in, s2_in, s3_in;
  word_t            in_w, s1_w, s2_w;
  logic [15:0]      count_q, count_d;

  // Per-stage transform; each stage picks its half of the cipher from the beat's own mode.
  always_comb begin
    in_w  = word_t'(in_data);
    s1_w  = word_t'(s1_data);
    s2_w  = word_t'(s2_data);
    s1_in = (in_mode == MODE_DEC) ? WIDTH'(~in_w)                : WIDTH'(rotr(in_w, WIDTH, SHIFT));
    s2_in = (s1_mode == MODE_DEC) ? WIDTH'(gray_inv(s1_w, WIDTH)) : WIDTH'(gray_fwd(s1_w, WIDTH));
    s3_in = (s2_mode == MODE_DEC) ? WIDTH'(rotl(s2_w, WIDTH, SHIFT)) : WIDTH'(~s2_w);
  end

  cipher_pipe_stage #(.W(WIDTH)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (in_valid),
    .up_data    (s1_in),
    .up_mode    (in_mode),
    .up_ready_c (in_ready),
    .dn_valid   (s1_valid),
    .dn_data    (s1_data),
    .dn_mode    (s1_mode),
    .dn_ready   (s2_ready_c)
  );

  cipher_pipe_stage #(.W(WIDTH)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (s1_valid),
    .up_data    (s2_in),
    .up_mode    (s1_mode),
    .up_ready_c (s2_ready_c),
    .dn_valid   (s2_valid),
    .dn_data    (s2_data),
    .dn_mode    (s2_mode),
    .dn_ready   (s3_ready_c)
  );

  cipher_pipe_stage #(.W(WIDTH)) u_s3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (s2_valid),
    .up_data    (s3_in),
    .up_mode    (s2_mode),
    .up_ready_c (s3_ready_c),
    .dn_valid   (out_valid),
    .dn_data    (out_data),
    .dn_mode    (out_mode),
    .dn_ready   (out_ready)
  );

  // Count completed output transfers; wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) begin
      count_d = count_q + 16'd1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;

endmodule

// File: tb/tb_param_cipher_pipe.sv
// Self-checking bench: table vectors, streaming, stall, mid-flight reset, 13-bit round trip.
module tb_param_cipher_pipe;

  typedef struct {
    logic [7:0] din;
    logic       mode;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic       mode;
    int         acc;
    bit         lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_mode;
  logic [7:0]  out_data;
  logic [15:0] out_count;

  logic        a_in_valid, a_in_ready, a_in_mode;
  logic [12:0] a_in_data;
  logic        a_out_valid, a_out_mode, b_in_ready, b_in_mode;
  logic [12:0] a_out_data;
  logic [15:0] a_out_count;
  logic        b_out_valid, b_out_ready, b_out_mode;
  logic [12:0] b_out_data;
  logic [15:0] b_out_count;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_n = 0;
  int          rt_acc = 0;
  int          last_acc_cyc = 0;
  int          last_out_cyc = 0;
  int          first_cyc = 0;
  bit          last_acc;
  logic [7:0]  nxt_exp;
  bit          nxt_lat;
  logic [7:0]  hold_exp;
  sb_t         sb_q[$];
  logic [12:0] rt_q[$];
  vec_t        vecs[6];
  logic [7:0]  stall_d[3];
  logic        stall_m[3];

  always #5 clk = ~clk;

  param_cipher_pipe #(.WIDTH(8), .SHIFT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .out_count(out_count)
  );

  param_cipher_pipe #(.WIDTH(13), .SHIFT(5)) u_enc13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(b_in_ready), .out_data(a_out_data), .out_mode(a_out_mode),
    .out_count(a_out_count)
  );

  param_cipher_pipe #(.WIDTH(13), .SHIFT(5)) u_dec13 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
    .out_count(b_out_count)
  );

  // Bit-level reference encrypt: rotate right, x ^ (x<<1), invert.
  function automatic logic [15:0] ref_enc(input logic [15:0] x, input int w, input int s);
    logic [15:0] a;
    logic [15:0] b;
    a = '0;
    b = '0;
    for (int i = 0; i < w; i++) a[4'(i)] = x[4'((i + s) % w)];
    for (int i = 0; i < w; i++) b[4'(i)] = ~(a[4'(i)] ^ ((i > 0) ? a[4'(i - 1)] : 1'b0));
    return b;
  endfunction

  // Bit-level reference decrypt: invert, prefix XOR, rotate left.
  function automatic logic [15:0] ref_dec(input logic [15:0] x, input int w, input int s);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    a = '0;
    b = '0;
    c = '0;
    for (int i = 0; i < w; i++) a[4'(i)] = ~x[4'(i)];
    b[0] = a[0];
    for (int i = 1; i < w; i++) b[4'(i)] = a[4'(i)] ^ b[4'(i - 1)];
    for (int i = 0; i < w; i++) c[4'((i + s) % w)] = b[4'(i)];
    return c;
  endfunction

  function automatic logic [7:0] model8(input logic [7:0] x, input logic m);
    return m ? 8'(ref_dec(16'(x), 8, 1)) : 8'(ref_enc(16'(x), 8, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshakes away from the edge, update scoreboards, advance to next negedge.
  task automatic tick();
    sb_t         e;
    logic [12:0] o;
    #1;
    last_acc = 1'b0;
    if (in_valid && in_ready) begin
      sb_q.push_back('{dat: nxt_exp, mode: in_mode, acc: cyc, lat: nxt_lat});
      last_acc = 1'b1;
      acc_n++;
      last_acc_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got data 0x%0h with nothing expected (cycle %0d)", out_data, cyc);
      end else begin
        e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.dat));
        check("out_mode", 32'(out_mode), 32'(e.mode));
        if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
        last_out_cyc = cyc;
      end
    end
    if (a_in_valid && a_in_ready) begin
      rt_q.push_back(a_in_data);
      rt_acc++;
    end
    if (b_out_valid && b_out_ready) begin
      if (rt_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rt_spurious: got data 0x%0h with nothing expected (cycle %0d)", b_out_data, cyc);
      end else begin
        o = rt_q.pop_front();
        check("rt_data", 32'(b_out_data), 32'(o));
        check("rt_mode", 32'(b_out_mode), 32'd1);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() > 0 || rt_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb_q.size() + rt_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a_in_valid = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    rt_q.delete();
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h01, 1'b0, 8'h7F};
    vecs[1] = '{8'hA5, 1'b0, 8'h89};
    vecs[2] = '{8'h7F, 1'b1, 8'h01};
    vecs[3] = '{8'h89, 1'b1, 8'hA5};
    vecs[4] = '{8'h00, 1'b0, 8'hFF};
    vecs[5] = '{8'hFE, 1'b1, 8'hFF};
    stall_d[0] = 8'h3C; stall_m[0] = 1'b0;
    stall_d[1] = 8'hC3; stall_m[1] = 1'b1;
    stall_d[2] = 8'h5A; stall_m[2] = 1'b0;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; b_in_mode = 1'b1; b_out_ready = 1'b1;
    nxt_exp = '0; nxt_lat = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Known vectors, one at a time, with 3-cycle latency.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      in_mode  = vecs[i].mode;
      nxt_exp  = vecs[i].dout;
      nxt_lat  = 1'b1;
      tick();
      check("tbl_accept", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      drain(10);
    end
    check("tbl_count", 32'(out_count), 32'd6);

    // 256 back-to-back beats with alternating modes.
    do_reset();
    acc_n = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_mode  = 1'(i % 2);
      nxt_exp  = model8(in_data, in_mode);
      nxt_lat  = 1'b1;
      tick();
      if (i == 0) first_cyc = last_acc_cyc;
    end
    in_valid = 1'b0;
    drain(20);
    check("stream_accepted", 32'(acc_n), 32'd256);
    check("stream_count", 32'(out_count), 32'h0100);
    check("stream_span", 32'(last_out_cyc - first_cyc), 32'd258);

    // Fill three beats, then hold the output stalled for five cycles.
    do_reset();
    acc_n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = stall_d[i];
      in_mode  = stall_m[i];
      nxt_exp  = model8(stall_d[i], stall_m[i]);
      nxt_lat  = 1'b0;
      tick();
    end
    hold_exp = model8(stall_d[0], stall_m[0]);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_mode  = 1'b0;
    nxt_exp  = model8(8'h77, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'(hold_exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(10);
    check("stall_accepted", 32'(acc_n), 32'd3);
    check("stall_count", 32'(out_count), 32'd3);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + 8'(i));
      in_mode  = 1'b0;
      nxt_exp  = model8(in_data, in_mode);
      nxt_lat  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    out_ready = 1'b1;
    tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_mode  = 1'b0;
    nxt_exp  = 8'h89;
    nxt_lat  = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(10);
    check("post_rst_count", 32'(out_count), 32'd1);

    // 13-bit encrypt->decrypt round trip with random backpressure.
    do_reset();
    rt_acc = 0;
    for (int i = 0; i < 300; i++) begin
      a_in_valid  = (($urandom % 4) != 0);
      a_in_data   = 13'($urandom);
      b_out_ready = (($urandom % 4) != 0);
      tick();
    end
    a_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    drain(40);
    check("rt_out_count", 32'(b_out_count), 32'(16'(rt_acc)));
    check("rt_enc_count", 32'(a_out_count), 32'(16'(rt_acc)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
